// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants, field positions and FSM states for the program sequencer
// Purpose: word width, mvi opcode, halt marker, opcode field slice and sequencer states.
// Ports:   none (package).
package proc_pkg;

   localparam int DW = 9;

   // Instruction word layout: [2:0] opcode, [5:3] Rx, [8:6] Ry
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 2;
   localparam int RX_LSB  = 3;
   localparam int RX_MSB  = 5;
   localparam int RY_LSB  = 6;
   localparam int RY_MSB  = 8;

   localparam logic [2:0]    OP_MVI    = 3'b001;
   localparam logic [DW-1:0] HALT_WORD = 9'h1FF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      IMM,
      WAIT,
      NEXT,
      HALT,
      ERROR
   } state_t;

   function automatic logic is_mvi(input logic [DW-1:0] word);
      return word[OPC_MSB:OPC_LSB] == OP_MVI;
   endfunction

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program word store, synchronous write and asynchronous read
// Purpose: 2**AW x DW register array holding the program; contents are not reset.
// Ports:   clk            write clock
//          we/waddr/wdata synchronous write port
//          raddr/rdata    combinational read port
module prog_mem #(
   parameter int DW = 9,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - Done-handshaked instruction feeder for simple_processor_Top
// Purpose: steps through a small program memory, presenting each instruction (and the
//          immediate word of an mvi) on DIN with a one-cycle Run pulse, then waits for
//          Done before moving on. A watchdog flags Error if Done never comes.
// Ports:   Clock, Resetn             clock and asynchronous active-low reset
//          Start                     level start request, sampled in IDLE
//          prog_we/addr/data         program load port (ignored while running)
//          prog_len                  number of valid program words
//          Done                      instruction complete from the processor
//          DIN, Run                  registered word and run strobe to the processor
//          PC                        address of the current instruction
//          Busy, Halted, Error       status
module program_sequencer #(
   parameter int DW      = proc_pkg::DW,
   parameter int AW      = 5,
   parameter int TIMEOUT = 16
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          Done,
   output logic [DW-1:0] DIN,
   output logic          Run,
   output logic [AW:0]   PC,
   output logic          Busy,
   output logic          Halted,
   output logic          Error
);

   import proc_pkg::*;

   localparam int TW = $clog2(TIMEOUT) + 1;

   state_t        state, state_n;
   logic [AW:0]   pc_n;
   logic [DW-1:0] din_n;
   logic          run_n;
   logic [TW-1:0] timer, timer_n;
   logic          mvi, mvi_n;

   logic [AW:0]   pc_plus1;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] rd_word;
   logic          mem_we;

   assign pc_plus1 = PC + (AW+1)'(1);

   // One read port: the immediate is fetched from PC+1 while in IMM.
   assign rd_ptr = (state == IMM) ? pc_plus1 : PC;
   assign mem_we = prog_we && (state == IDLE || state == HALT || state == ERROR);

   prog_mem #(.DW(DW), .AW(AW)) u_mem (
      .clk   (Clock),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_word)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= IDLE;
         PC    <= '0;
         DIN   <= '0;
         Run   <= 1'b0;
         timer <= '0;
         mvi   <= 1'b0;
      end else begin
         state <= state_n;
         PC    <= pc_n;
         DIN   <= din_n;
         Run   <= run_n;
         timer <= timer_n;
         mvi   <= mvi_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = PC;
      din_n   = DIN;
      run_n   = 1'b0;
      timer_n = timer;
      mvi_n   = mvi;

      case (state)
         IDLE: begin
            if (Start) begin
               pc_n    = '0;
               state_n = (prog_len == '0) ? HALT : ISSUE;
            end
         end
         ISSUE: begin
            // Length check first: a PC at or past the end may alias a valid address.
            if (PC >= prog_len || rd_word == HALT_WORD) begin
               state_n = HALT;
            end else begin
               din_n   = rd_word;
               run_n   = 1'b1;
               timer_n = '0;
               mvi_n   = is_mvi(rd_word);
               state_n = mvi_n ? IMM : WAIT;
            end
         end
         IMM, WAIT: begin
            if (state == IMM) begin
               din_n = (pc_plus1 >= prog_len) ? '0 : rd_word;
            end
            // Done takes priority over a watchdog expiring in the same cycle.
            if (Done) begin
               state_n = NEXT;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               state_n = ERROR;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         NEXT: begin
            pc_n    = PC + (mvi ? (AW+1)'(2) : (AW+1)'(1));
            state_n = ISSUE;
         end
         HALT, ERROR: begin
            if (!Start) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign Busy   = (state == ISSUE) || (state == IMM) || (state == WAIT);
   assign Halted = (state == HALT);
   assign Error  = (state == ERROR);

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer
module tb_program_sequencer;

   localparam int DW = 9;
   localparam int AW = 5;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic          Start;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [AW:0]   prog_len;
   logic          Done;
   logic [DW-1:0] DIN;
   logic          Run;
   logic [AW:0]   PC;
   logic          Busy;
   logic          Halted;
   logic          Error;

   int total = 0;
   int bad   = 0;
   int run_cnt = 0;
   int base;
   bit ok;

   program_sequencer #(.DW(DW), .AW(AW), .TIMEOUT(16)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .Start     (Start),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_len  (prog_len),
      .Done      (Done),
      .DIN       (DIN),
      .Run       (Run),
      .PC        (PC),
      .Busy      (Busy),
      .Halted    (Halted),
      .Error     (Error)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (Run === 1'b1) run_cnt++;
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      step();
      prog_we   = 1'b0;
   endtask

   task automatic wait_run(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (Run === 1'b1) found = 1'b1;
      end
   endtask

   task automatic wait_halt(output bit found);
      found = (Halted === 1'b1);
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (Halted === 1'b1) found = 1'b1;
      end
   endtask

   // Waits for Run, checks the word and PC, checks the following cycle, then returns Done.
   task automatic do_instr(input string tag, input logic [DW-1:0] w, input bit two_word,
                           input logic [DW-1:0] imm, input int pc_exp);
      bit f;
      wait_run(f);
      chk({tag, "_run_seen"}, 32'(f), 1);
      chk({tag, "_din"}, 32'(DIN), 32'(w));
      chk({tag, "_pc"}, 32'(PC), 32'(pc_exp));
      step();
      chk({tag, "_run_pulse"}, 32'(Run), 0);
      chk({tag, "_din_next"}, 32'(DIN), two_word ? 32'(imm) : 32'(w));
      step();
      step();
      Done = 1'b1;
      step();
      Done = 1'b0;
   endtask

   task automatic load_prog_a();
      load(5'd0, 9'h0C1);
      load(5'd1, 9'h1F0);
      load(5'd2, 9'h0D1);
      load(5'd3, 9'h10F);
      load(5'd4, 9'h082);
   endtask

   initial begin
      Resetn = 1'b0; Start = 1'b0; prog_we = 1'b0; prog_addr = '0;
      prog_data = '0; prog_len = '0; Done = 1'b0;
      step(); step();
      chk("rst_din", 32'(DIN), 0);
      chk("rst_run", 32'(Run), 0);
      chk("rst_pc", 32'(PC), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_halted", 32'(Halted), 0);
      chk("rst_error", 32'(Error), 0);
      Resetn = 1'b1;
      step();

      // Main program: mvi, mvi, one-word op
      load_prog_a();
      prog_len = 6'd5;
      base = run_cnt;
      Start = 1'b1;
      do_instr("a0", 9'h0C1, 1'b1, 9'h1F0, 0);
      do_instr("a1", 9'h0D1, 1'b1, 9'h10F, 2);
      do_instr("a2", 9'h082, 1'b0, 9'h000, 4);
      wait_halt(ok);
      chk("a_halted", 32'(ok), 1);
      chk("a_pc_end", 32'(PC), 5);
      chk("a_runs", 32'(run_cnt - base), 3);
      step(); step(); step();
      chk("a_hold_halt", 32'(Halted), 1);
      chk("a_no_restart", 32'(run_cnt - base), 3);
      Start = 1'b0;
      step();
      chk("a_idle_halted", 32'(Halted), 0);
      chk("a_idle_busy", 32'(Busy), 0);

      // Halt marker at address 1
      load(5'd0, 9'h082);
      load(5'd1, 9'h1FF);
      base = run_cnt;
      Start = 1'b1;
      do_instr("h0", 9'h082, 1'b0, 9'h000, 0);
      wait_halt(ok);
      chk("h_halted", 32'(ok), 1);
      chk("h_pc", 32'(PC), 1);
      chk("h_runs", 32'(run_cnt - base), 1);
      Start = 1'b0;
      step();

      // Done never arrives: watchdog
      prog_len = 6'd1;
      base = run_cnt;
      Start = 1'b1;
      wait_run(ok);
      chk("t_run_seen", 32'(ok), 1);
      for (int i = 0; i < 15; i++) step();
      chk("t_err_early", 32'(Error), 0);
      chk("t_busy_late", 32'(Busy), 1);
      step();
      chk("t_error", 32'(Error), 1);
      chk("t_run_low", 32'(Run), 0);
      chk("t_runs", 32'(run_cnt - base), 1);
      Start = 1'b0;
      step();
      chk("t_error_clear", 32'(Error), 0);

      // mvi as the last valid word: immediate reads as 0 despite 1FF at address 1
      load(5'd0, 9'h0C1);
      Start = 1'b1;
      do_instr("m0", 9'h0C1, 1'b1, 9'h000, 0);
      wait_halt(ok);
      chk("m_halted", 32'(ok), 1);
      chk("m_pc", 32'(PC), 2);
      Start = 1'b0;
      step();

      // Write attempted while busy is dropped
      load(5'd0, 9'h082);
      Start = 1'b1;
      wait_run(ok);
      chk("w_run_seen", 32'(ok), 1);
      chk("w_busy", 32'(Busy), 1);
      load(5'd0, 9'h0AA);
      Done = 1'b1;
      step();
      Done = 1'b0;
      wait_halt(ok);
      chk("w_halted", 32'(ok), 1);
      Start = 1'b0;
      step();
      Start = 1'b1;
      do_instr("w1", 9'h082, 1'b0, 9'h000, 0);
      wait_halt(ok);
      Start = 1'b0;
      step();

      // Asynchronous reset while waiting on Done at PC=4
      load_prog_a();
      prog_len = 6'd5;
      Start = 1'b1;
      do_instr("r0", 9'h0C1, 1'b1, 9'h1F0, 0);
      do_instr("r1", 9'h0D1, 1'b1, 9'h10F, 2);
      wait_run(ok);
      chk("r_pc4", 32'(PC), 4);
      step();
      chk("r_busy_wait", 32'(Busy), 1);
      #2;
      Resetn = 1'b0;
      #1;
      chk("r_run", 32'(Run), 0);
      chk("r_din", 32'(DIN), 0);
      chk("r_pc", 32'(PC), 0);
      chk("r_busy", 32'(Busy), 0);
      Start = 1'b0;
      step();
      Resetn = 1'b1;
      step();
      chk("r_idle_busy", 32'(Busy), 0);
      chk("r_idle_halted", 32'(Halted), 0);
      chk("r_idle_error", 32'(Error), 0);
      Start = 1'b1;
      wait_run(ok);
      chk("r_restart_run", 32'(ok), 1);
      chk("r_restart_din", 32'(DIN), 32'h0C1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
